// File: rtl/chest_ls_pkg.sv
// Shared types and helpers for the least-squares channel estimator.
package chest_ls_pkg;

  typedef enum logic {
    S_PILOT = 1'b0,
    S_DATA  = 1'b1
  } state_t;

  // Width used by the shift/saturate helper. It must cover any accumulator width.
  localparam int WIDE_W = 64;

  // The accumulator holds up to 2**log2_pilot_max samples, plus the sign bit
  // that lets the most negative sample be negated safely.
  function automatic int acc_width(input int samp_w, input int log2_pilot_max);
    return samp_w + log2_pilot_max + 1;
  endfunction

  // Arithmetic right shift (floor division by 2**sh), then clamp to a
  // signed samp_w-bit range.
  function automatic logic signed [WIDE_W-1:0] shift_sat(
    input logic signed [WIDE_W-1:0] v,
    input int                       sh,
    input int                       samp_w
  );
    logic signed [WIDE_W-1:0] s;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    s  = v >>> sh;
    hi = (64'sd1 <<< (samp_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (samp_w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/chest_ls_acc.sv
// One channel's I/Q pilot accumulator: sign-corrects each pilot sample,
// accumulates it, and produces the shifted, saturated estimate.
module chest_ls_acc
  import chest_ls_pkg::*;
#(
  parameter int SAMP_W         = 16,
  parameter int LOG2_PILOT_MAX = 6,
  parameter int LEN_W          = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                neg,
  input  logic [LEN_W-1:0]    len_log2,
  input  logic [2*SAMP_W-1:0] x,
  output logic [2*SAMP_W-1:0] est
);

  localparam int ACC_W = acc_width(SAMP_W, LOG2_PILOT_MAX);

  logic signed [SAMP_W-1:0] x_i;
  logic signed [SAMP_W-1:0] x_q;
  logic signed [ACC_W-1:0]  term_i;
  logic signed [ACC_W-1:0]  term_q;
  logic signed [ACC_W-1:0]  sum_i;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  acc_i;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [SAMP_W-1:0] est_i;
  logic signed [SAMP_W-1:0] est_q;

  assign x_i = x[2*SAMP_W-1:SAMP_W];
  assign x_q = x[SAMP_W-1:0];

  // Sign-extend first, then negate at full width so -2**(SAMP_W-1) is exact.
  always_comb begin
    term_i = {{(ACC_W-SAMP_W){x_i[SAMP_W-1]}}, x_i};
    term_q = {{(ACC_W-SAMP_W){x_q[SAMP_W-1]}}, x_q};
    if (neg) begin
      term_i = -term_i;
      term_q = -term_q;
    end
    sum_i = acc_i + term_i;
    sum_q = acc_q + term_q;
    est_i = SAMP_W'(shift_sat({{(WIDE_W-ACC_W){sum_i[ACC_W-1]}}, sum_i},
                              int'(len_log2), SAMP_W));
    est_q = SAMP_W'(shift_sat({{(WIDE_W-ACC_W){sum_q[ACC_W-1]}}, sum_q},
                              int'(len_log2), SAMP_W));
  end

  assign est = {est_i, est_q};

  // Accumulate on every pilot beat; clear when the preamble ends or is cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (clr) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (en) begin
      acc_i <= sum_i;
      acc_q <= sum_q;
    end
  end

endmodule

// File: rtl/chest_ls_estimator.sv
// Multi-channel LS channel estimator: averages the sign-corrected pilot
// preamble per channel, emits one estimate per packet, then forwards the data.
module chest_ls_estimator
  import chest_ls_pkg::*;
#(
  parameter int NUM_CHAN       = 1,
  parameter int SAMP_W         = 16,
  parameter int LOG2_PILOT_MAX = 6
) (
  input  logic                                  ce_clk,
  input  logic                                  ce_rst,
  input  logic [$clog2(LOG2_PILOT_MAX+1)-1:0]   cfg_pilot_len_log2,
  input  logic [2**LOG2_PILOT_MAX-1:0]          cfg_pilot_seq,
  input  logic                                  err_clr,
  input  logic [NUM_CHAN*2*SAMP_W-1:0]          s_axis_tdata,
  input  logic                                  s_axis_tlast,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  output logic [NUM_CHAN*2*SAMP_W-1:0]          m_axis_tdata,
  output logic                                  m_axis_tlast,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [NUM_CHAN*2*SAMP_W-1:0]          est_tdata,
  output logic                                  est_valid,
  output logic                                  err_short
);

  localparam int LEN_W     = $clog2(LOG2_PILOT_MAX + 1);
  localparam int PILOT_MAX = 2 ** LOG2_PILOT_MAX;
  localparam int CNT_W     = LOG2_PILOT_MAX;
  localparam int BEAT_W    = NUM_CHAN * 2 * SAMP_W;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [LEN_W-1:0]     len_q;
  logic [PILOT_MAX-1:0] seq_q;
  logic [LEN_W-1:0]     cfg_len_clamped;
  logic [LEN_W-1:0]     cur_len;
  logic [PILOT_MAX-1:0] cur_seq;
  logic [CNT_W-1:0]     last_idx;
  logic                 cur_neg;
  logic                 pilot_hs;
  logic                 pilot_last;
  logic                 data_hs;
  logic                 acc_clr;
  logic [BEAT_W-1:0]    est_comb;

  assign cfg_len_clamped = (cfg_pilot_len_log2 > LEN_W'(LOG2_PILOT_MAX))
                           ? LEN_W'(LOG2_PILOT_MAX) : cfg_pilot_len_log2;

  // The first pilot beat uses the live config, later beats the latched copy.
  always_comb begin
    cur_len  = (cnt == '0) ? cfg_len_clamped : len_q;
    cur_seq  = (cnt == '0) ? cfg_pilot_seq : seq_q;
    last_idx = '0;
    for (int i = 0; i < CNT_W; i++) begin
      last_idx[i] = (i < int'(cur_len));
    end
    cur_neg    = cur_seq[cnt];
    pilot_hs   = (state == S_PILOT) && s_axis_tvalid;
    pilot_last = (cnt == last_idx);
    data_hs    = (state == S_DATA) && s_axis_tvalid && s_axis_tready;
    acc_clr    = pilot_hs && (pilot_last || s_axis_tlast);
  end

  // Next-state logic and input ready.
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b1;
    case (state)
      S_PILOT: begin
        if (pilot_hs && pilot_last && !s_axis_tlast) state_next = S_DATA;
      end
      S_DATA: begin
        s_axis_tready = !m_axis_tvalid || m_axis_tready;
        if (data_hs && s_axis_tlast) state_next = S_PILOT;
      end
      default: state_next = S_PILOT;
    endcase
  end

  // State register.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) state <= S_PILOT;
    else        state <= state_next;
  end

  // Pilot counter and per-packet config latch.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      cnt   <= '0;
      len_q <= '0;
      seq_q <= '0;
    end else if (pilot_hs) begin
      if (cnt == '0) begin
        len_q <= cfg_len_clamped;
        seq_q <= cfg_pilot_seq;
      end
      if (pilot_last || s_axis_tlast) cnt <= '0;
      else                            cnt <= cnt + 1'b1;
    end
  end

  // One accumulator per channel, all driven in lock-step.
  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    chest_ls_acc #(
      .SAMP_W         (SAMP_W),
      .LOG2_PILOT_MAX (LOG2_PILOT_MAX),
      .LEN_W          (LEN_W)
    ) u_acc (
      .clk      (ce_clk),
      .rst      (ce_rst),
      .en       (pilot_hs),
      .clr      (acc_clr),
      .neg      (cur_neg),
      .len_log2 (cur_len),
      .x        (s_axis_tdata[c*2*SAMP_W +: 2*SAMP_W]),
      .est      (est_comb[c*2*SAMP_W +: 2*SAMP_W])
    );
  end

  // Estimate register: updates and strobes on the final pilot beat.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      est_tdata <= '0;
      est_valid <= 1'b0;
    end else begin
      est_valid <= pilot_hs && pilot_last;
      if (pilot_hs && pilot_last) est_tdata <= est_comb;
    end
  end

  // Short-packet flag: a new event takes priority over a clear.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst)                                        err_short <= 1'b0;
    else if (pilot_hs && s_axis_tlast && !pilot_last)  err_short <= 1'b1;
    else if (err_clr)                                  err_short <= 1'b0;
  end

  // Data output register; contents hold while the downstream stalls.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (data_hs) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chest_ls_estimator.sv
// Directed bench for chest_ls_estimator with two channels of 16-bit samples.
module tb_chest_ls_estimator;

  logic        ce_clk = 1'b0;
  logic        ce_rst;
  logic [2:0]  cfg_pilot_len_log2;
  logic [63:0] cfg_pilot_seq;
  logic        err_clr;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] est_tdata;
  logic        est_valid;
  logic        err_short;

  int vectors    = 0;
  int miscompares = 0;

  int          ready_mode = 0;  // 0: always ready, 1: 25% stall, 2: never ready
  logic [64:0] out_q[$];
  int          est_cnt   = 0;
  logic [63:0] est_seen  = '0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] held_d;
  logic        held_l;

  chest_ls_estimator #(
    .NUM_CHAN       (2),
    .SAMP_W         (16),
    .LOG2_PILOT_MAX (6)
  ) dut (
    .ce_clk             (ce_clk),
    .ce_rst             (ce_rst),
    .cfg_pilot_len_log2 (cfg_pilot_len_log2),
    .cfg_pilot_seq      (cfg_pilot_seq),
    .err_clr            (err_clr),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .est_tdata          (est_tdata),
    .est_valid          (est_valid),
    .err_short          (err_short)
  );

  always #5 ce_clk = ~ce_clk;

  // Downstream ready generator.
  always @(posedge ce_clk) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge ce_clk) begin
    if (ce_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
      if (est_valid) begin
        est_cnt++;
        est_seen = est_tdata;
      end
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== held_d || m_axis_tlast !== held_l))
        stall_err++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held_d = m_axis_tdata;
      held_l = m_axis_tlast;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pk(input int i0, input int q0, input int i1, input int q1);
    logic [15:0] a, b, c, d;
    a = i0[15:0]; b = q0[15:0]; c = i1[15:0]; d = q1[15:0];
    return {c, d, a, b};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge ce_clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    logic hs;
    logic got;
    got = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge ce_clk);
      hs = s_axis_tready;
      @(posedge ce_clk);
      #1;
      if (hs) begin
        got = 1'b1;
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: beat %h not accepted within 2000 cycles", d);
    end
  endtask

  task automatic test_reset();
    ce_rst = 1'b1;
    err_clr = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
    cfg_pilot_len_log2 = '0; cfg_pilot_seq = '0;
    m_axis_tready = 1'b1;
    tick(3);
    vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b expected 0", m_axis_tvalid); end
    vectors++; if (m_axis_tdata !== 64'h0) begin miscompares++; $display("FAIL reset_m_data: got %h expected 0", m_axis_tdata); end
    vectors++; if (est_valid !== 1'b0) begin miscompares++; $display("FAIL reset_est_valid: got %b expected 0", est_valid); end
    vectors++; if (est_tdata !== 64'h0) begin miscompares++; $display("FAIL reset_est_data: got %h expected 0", est_tdata); end
    vectors++; if (err_short !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_short); end
    vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", s_axis_tready); end
    ce_rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int e0;
    logic [64:0] exp_b;
    cfg_pilot_len_log2 = 3'd2; cfg_pilot_seq = '0;
    out_q.delete(); e0 = est_cnt;
    repeat (4) send_beat(pk(100, -50, -8, 8), 1'b0);
    for (int k = 0; k < 6; k++) send_beat(pk(k + 1, -(k + 1), 1000 * k, -7), k == 5);
    tick(4);
    vectors++; if (est_cnt - e0 !== 1) begin miscompares++; $display("FAIL basic_est_count: got %0d expected 1", est_cnt - e0); end
    vectors++; if (est_seen !== pk(100, -50, -8, 8)) begin miscompares++; $display("FAIL basic_est: got %h expected %h", est_seen, pk(100, -50, -8, 8)); end
    vectors++; if (est_tdata !== pk(100, -50, -8, 8)) begin miscompares++; $display("FAIL basic_est_hold: got %h expected %h", est_tdata, pk(100, -50, -8, 8)); end
    vectors++; if (est_valid !== 1'b0) begin miscompares++; $display("FAIL basic_est_strobe: got %b expected 0", est_valid); end
    vectors++; if (out_q.size() !== 6) begin miscompares++; $display("FAIL basic_out_count: got %0d expected 6", out_q.size()); end
    for (int k = 0; k < 6 && k < out_q.size(); k++) begin
      exp_b = {k == 5, pk(k + 1, -(k + 1), 1000 * k, -7)};
      vectors++; if (out_q[k] !== exp_b) begin miscompares++; $display("FAIL basic_data[%0d]: got %h expected %h", k, out_q[k], exp_b); end
    end
  endtask

  task automatic test_alt_seq();
    int e0;
    cfg_pilot_len_log2 = 3'd2; cfg_pilot_seq = 64'b1010;
    out_q.delete(); e0 = est_cnt;
    send_beat(pk(10, 0, 3, 5), 1'b0);
    send_beat(pk(-10, 0, -3, 5), 1'b0);
    send_beat(pk(10, 0, 3, 5), 1'b0);
    send_beat(pk(-10, 0, -3, 5), 1'b1);  // packet ends exactly on the last pilot
    tick(3);
    vectors++; if (est_cnt - e0 !== 1) begin miscompares++; $display("FAIL alt_est_count: got %0d expected 1", est_cnt - e0); end
    vectors++; if (est_seen !== pk(10, 0, 3, 0)) begin miscompares++; $display("FAIL alt_est: got %h expected %h", est_seen, pk(10, 0, 3, 0)); end
    vectors++; if (out_q.size() !== 0) begin miscompares++; $display("FAIL alt_no_data: got %0d beats expected 0", out_q.size()); end
    vectors++; if (err_short !== 1'b0) begin miscompares++; $display("FAIL alt_err: got %b expected 0", err_short); end
  endtask

  task automatic test_saturation();
    int e0;
    cfg_pilot_len_log2 = 3'd1; cfg_pilot_seq = 64'b11;
    out_q.delete(); e0 = est_cnt;
    send_beat(pk(-32768, -1, 1, 0), 1'b0);
    send_beat(pk(-32768, -2, 0, 0), 1'b0);
    send_beat(pk(1, 2, 3, 4), 1'b1);
    tick(3);
    vectors++; if (est_cnt - e0 !== 1) begin miscompares++; $display("FAIL sat_est_count: got %0d expected 1", est_cnt - e0); end
    vectors++; if (est_seen !== pk(32767, 1, -1, 0)) begin miscompares++; $display("FAIL sat_est: got %h expected %h", est_seen, pk(32767, 1, -1, 0)); end
    vectors++; if (out_q.size() !== 1) begin miscompares++; $display("FAIL sat_out_count: got %0d expected 1", out_q.size()); end
    if (out_q.size() > 0) begin
      vectors++; if (out_q[0] !== {1'b1, pk(1, 2, 3, 4)}) begin miscompares++; $display("FAIL sat_data: got %h expected %h", out_q[0], {1'b1, pk(1, 2, 3, 4)}); end
    end
  endtask

  task automatic test_short();
    int e0;
    cfg_pilot_len_log2 = 3'd3; cfg_pilot_seq = '0;
    out_q.delete(); e0 = est_cnt;
    for (int k = 0; k < 5; k++) send_beat(pk(50, 50, 50, 50), k == 4);
    tick(2);
    vectors++; if (err_short !== 1'b1) begin miscompares++; $display("FAIL short_err_set: got %b expected 1", err_short); end
    vectors++; if (est_cnt - e0 !== 0) begin miscompares++; $display("FAIL short_no_est: got %0d expected 0", est_cnt - e0); end
    vectors++; if (out_q.size() !== 0) begin miscompares++; $display("FAIL short_no_data: got %0d expected 0", out_q.size()); end
    // Next packet; config is changed after the first beat and must be ignored.
    e0 = est_cnt;
    for (int k = 1; k <= 8; k++) begin
      send_beat(pk(k, -3, 7, 0), 1'b0);
      cfg_pilot_len_log2 = 3'd0; cfg_pilot_seq = '1;
    end
    send_beat(pk(11, 12, 13, 14), 1'b0);
    send_beat(pk(21, 22, 23, 24), 1'b1);
    tick(3);
    vectors++; if (est_cnt - e0 !== 1) begin miscompares++; $display("FAIL short_next_est_count: got %0d expected 1", est_cnt - e0); end
    vectors++; if (est_seen !== pk(4, -3, 7, 0)) begin miscompares++; $display("FAIL short_next_est: got %h expected %h", est_seen, pk(4, -3, 7, 0)); end
    vectors++; if (out_q.size() !== 2) begin miscompares++; $display("FAIL short_next_data: got %0d expected 2", out_q.size()); end
    vectors++; if (err_short !== 1'b1) begin miscompares++; $display("FAIL short_sticky: got %b expected 1", err_short); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    vectors++; if (err_short !== 1'b0) begin miscompares++; $display("FAIL short_clr: got %b expected 0", err_short); end
  endtask

  task automatic test_random_stall();
    logic [64:0] exp_q[$];
    logic [15:0] v[4];
    longint      sm[4];
    longint      e;
    logic [15:0] ev[4];
    logic [63:0] seq;
    logic [63:0] exp_est;
    int          len, eff, nd, e0, n;
    out_q.delete();
    ready_mode = 1;
    stall_err = 0;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(0, 7);
      eff = (len > 6) ? 6 : len;
      seq = {$urandom, $urandom};
      cfg_pilot_len_log2 = len[2:0];
      cfg_pilot_seq = seq;
      for (int j = 0; j < 4; j++) sm[j] = 0;
      e0 = est_cnt;
      for (int k = 0; k < (1 << eff); k++) begin
        for (int j = 0; j < 4; j++) begin
          v[j] = 16'($urandom);
          if (seq[k]) sm[j] = sm[j] - longint'($signed(v[j]));
          else        sm[j] = sm[j] + longint'($signed(v[j]));
        end
        send_beat({v[3], v[2], v[1], v[0]}, 1'b0);
      end
      for (int j = 0; j < 4; j++) begin
        e = sm[j] >>> eff;
        if (e > 32767)  e = 32767;
        if (e < -32768) e = -32768;
        ev[j] = e[15:0];
      end
      exp_est = {ev[3], ev[2], ev[1], ev[0]};
      nd = $urandom_range(1, 4);
      for (int k = 0; k < nd; k++) begin
        for (int j = 0; j < 4; j++) v[j] = 16'($urandom);
        exp_q.push_back({k == nd - 1, v[3], v[2], v[1], v[0]});
        send_beat({v[3], v[2], v[1], v[0]}, k == nd - 1);
      end
      vectors++; if (est_cnt - e0 !== 1) begin miscompares++; $display("FAIL rand_est_count[%0d]: got %0d expected 1", p, est_cnt - e0); end
      vectors++; if (est_seen !== exp_est) begin miscompares++; $display("FAIL rand_est[%0d]: got %h expected %h", p, est_seen, exp_est); end
    end
    tick(10);
    ready_mode = 0;
    tick(10);
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_out_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      vectors++; if (out_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL rand_data[%0d]: got %h expected %h", k, out_q[k], exp_q[k]); end
    end
    vectors++; if (stall_err !== 0) begin miscompares++; $display("FAIL rand_stall_hold: got %0d unstable cycles expected 0", stall_err); end
  endtask

  task automatic test_reset_mid_data();
    int e0;
    ready_mode = 2;
    cfg_pilot_len_log2 = 3'd0; cfg_pilot_seq = '0;
    send_beat(pk(5, 6, 7, 8), 1'b0);
    send_beat(pk(1, 1, 1, 1), 1'b0);
    tick(2);
    vectors++; if (m_axis_tvalid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_valid: got %b expected 1", m_axis_tvalid); end
    @(negedge ce_clk);
    ce_rst = 1'b1;
    #1;
    vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid: got %b expected 0", m_axis_tvalid); end
    vectors++; if (m_axis_tdata !== 64'h0) begin miscompares++; $display("FAIL rst_m_data: got %h expected 0", m_axis_tdata); end
    vectors++; if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_m_last: got %b expected 0", m_axis_tlast); end
    vectors++; if (est_tdata !== 64'h0) begin miscompares++; $display("FAIL rst_est_data: got %h expected 0", est_tdata); end
    @(posedge ce_clk);
    #1;
    ce_rst = 1'b0;
    ready_mode = 0;
    tick(1);
    out_q.delete(); e0 = est_cnt;
    send_beat(pk(9, -9, 2, -2), 1'b0);
    send_beat(pk(3, 3, 3, 3), 1'b1);
    tick(3);
    vectors++; if (est_cnt - e0 !== 1) begin miscompares++; $display("FAIL rst_next_est_count: got %0d expected 1", est_cnt - e0); end
    vectors++; if (est_seen !== pk(9, -9, 2, -2)) begin miscompares++; $display("FAIL rst_next_est: got %h expected %h", est_seen, pk(9, -9, 2, -2)); end
    vectors++; if (out_q.size() !== 1) begin miscompares++; $display("FAIL rst_next_out_count: got %0d expected 1", out_q.size()); end
    if (out_q.size() > 0) begin
      vectors++; if (out_q[0] !== {1'b1, pk(3, 3, 3, 3)}) begin miscompares++; $display("FAIL rst_next_data: got %h expected %h", out_q[0], {1'b1, pk(3, 3, 3, 3)}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alt_seq();
    test_saturation();
    test_short();
    test_random_stall();
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
